comunicaciones_cmd_sched: RTL and testbench
===========================================

// Module: comunicaciones_cmd_sched
// PURPOSE
//  Shares the single UART command transmitter (Comunicaciones: command/str/ready_command/tx)
//  between N_REQ requesters. Arbitrates round-robin and drives command + str into the core.
//  Tracks each byte through ready_command until it is finished, then enforces an inter-frame gap.
//  Sits between the control logic (requesters) and the Comunicaciones instance.
// PARAMETERS
//  N_REQ        4     number of requesters (>=1)
//  CMD_W        8     command byte width
//  STR_CYCLES   5     cycles str_out is held high per issue (>=1)
//  ACK_TIMEOUT  1023  max cycles in WAIT_BUSY for ready_in to fall
//  GAP_CYCLES   16    idle cycles forced between frames (0 allowed)
// PORTS
//  clk          in   1            system clock (50 MHz)
//  rst          in   1            synchronous, active-high reset
//  req_valid    in   N_REQ        requester i has a byte pending (level, held until req_ack[i])
//  req_cmd      in   N_REQ*CMD_W  byte of requester i at bits [i*CMD_W +: CMD_W]
//  req_ack      out  N_REQ        1-cycle pulse: byte of requester i latched (requester may drop/change)
//  req_done     out  N_REQ        1-cycle pulse: byte of requester i fully transmitted
//  cmd_out      out  CMD_W        to core `command`
//  str_out      out  1            to core `str`
//  ready_in     in   1            from core `ready_command`; high = transmitter idle
//  busy         out  1            high in any state other than IDLE
//  grant_id     out  $clog2(N_REQ) index of the current/last granted requester (width 1 if N_REQ=1)
//  timeout_err  out  1            1-cycle pulse on ACK_TIMEOUT expiry
// BEHAVIOUR
//  Reset: all outputs 0; rr_ptr=0; state IDLE; counters 0. Takes effect at the next clk edge.
//  Reset mid-frame: str_out low after that edge. No req_done for the in-flight byte.
//  FSM:
//   IDLE: if ready_in && |req_valid, pick g = first set bit at or after rr_ptr (wrapping).
//    Same edge: cmd_out<=req_cmd[g], grant_id<=g, req_ack[g]=1 (next cycle), rr_ptr<=(g+1)%N_REQ.
//    Next state: ISSUE. If ready_in=0, stay in IDLE. Requests are sampled only here.
//   ISSUE: str_out=1 for exactly STR_CYCLES cycles, then WAIT_BUSY with str_out=0.
//    req_ack and the first str_out cycle coincide.
//   WAIT_BUSY: ready_in==0 -> WAIT_DONE.
//    After ACK_TIMEOUT cycles with ready_in still 1: pulse timeout_err, go to GAP, no req_done.
//   WAIT_DONE: ready_in rises to 1 -> pulse req_done[grant_id] on the next cycle, go to GAP.
//    No timeout here; the core owns frame length.
//   GAP: count GAP_CYCLES (0 = one-cycle pass-through), then IDLE.
//  cmd_out stays stable from the ISSUE entry until the next grant. It is never changed while str_out=1.
//  Latency: req_valid seen in IDLE with ready_in=1 -> req_ack and str_out at +1 cycle.
//  Simultaneous requests: round-robin from rr_ptr. No requester is starved; worst-case wait is N_REQ-1 frames.
//  A requester that drops req_valid before ack is simply not served. No stored state.
//  req_ack and req_done are never asserted for two requesters in the same cycle. Both are one-hot or zero.
//  Counters: str counter $clog2(STR_CYCLES+1) bits; timeout counter $clog2(ACK_TIMEOUT+1) bits.
//   Saturating compare, no wrap.
// STRUCTURE
//  comunicaciones_pkg: state enum {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP}; CMD_W default constant.
//  Sub-module rr_arbiter (N): in req + ptr, out one-hot grant + encoded index. Purely combinational.
//  FSM, counters, and output registers live in this module.
// TESTING
//  1) Single req: req_valid=4'b0001, req_cmd[0]=8'h01, core model busy for 100 cycles.
//     -> ack at +1, str_out high 5 cycles, cmd_out=8'h01, req_done[0] after ready_in rises.
//  2) All four req_valid=4'b1111 with cmds 00/01/02/04.
//     -> grants in order 0,1,2,3, each separated by >= GAP_CYCLES idle cycles, each gets exactly one done.
//  3) Fairness: req0 held permanently, req2 raised mid-frame -> next grant is 2, then 0 again.
//  4) Core stuck (ready_in tied 1 after str).
//     -> timeout_err pulse after 1023 cycles in WAIT_BUSY, no req_done, back to IDLE after the gap.
//  5) ready_in=0 at request time -> no ack until ready_in=1, then normal issue.
//  6) rst asserted during WAIT_DONE -> all outputs 0 next cycle, no req_done, a new request is served normally.

Source files
------------

// File: rtl/comunicaciones_pkg.sv
// Shared types for the Comunicaciones command scheduler: FSM state encoding and default byte width.
package comunicaciones_pkg;

  localparam int CMD_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sel = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/comunicaciones_cmd_sched.sv
// Round-robin scheduler sharing one UART command transmitter between N_REQ requesters,
// tracking each byte through ready_command and enforcing an inter-frame gap.
module comunicaciones_cmd_sched
  import comunicaciones_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CMD_W       = CMD_W_DEF,
  parameter int STR_CYCLES  = 5,
  parameter int ACK_TIMEOUT = 1023,
  parameter int GAP_CYCLES  = 16,
  localparam int GID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CMD_W-1:0] req_cmd,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       req_done,
  output logic [CMD_W-1:0]       cmd_out,
  output logic                   str_out,
  input  logic                   ready_in,
  output logic                   busy,
  output logic [GID_W-1:0]       grant_id,
  output logic                   timeout_err,
  output state_t                 dbg_state
);

  localparam int STR_W      = $clog2(STR_CYCLES + 1);
  localparam int TO_W       = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  // Handshake: req_valid is a level held until the one-cycle req_ack pulse; requests are
  // only sampled in IDLE with ready_in high, so a dropped request is simply never served.

  state_t             state, state_n;
  logic [STR_W-1:0]   str_cnt, str_cnt_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [GID_W-1:0]   rr_ptr, ptr_n;
  logic [CMD_W-1:0]   cmd_n;
  logic [GID_W-1:0]   gid_n;
  logic [N_REQ-1:0]   ack_n, done_n;
  logic               str_n, to_err_n;

  logic [N_REQ-1:0]   arb_grant;
  logic [GID_W-1:0]   arb_idx;
  logic               arb_found;

  rr_arbiter #(.N(N_REQ), .IDX_W(GID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_n   = state;
    str_cnt_n = str_cnt;
    to_cnt_n  = to_cnt;
    gap_cnt_n = gap_cnt;
    ptr_n     = rr_ptr;
    cmd_n     = cmd_out;
    gid_n     = grant_id;
    ack_n     = '0;
    done_n    = '0;
    str_n     = 1'b0;
    to_err_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ready_in && arb_found) begin
          state_n   = ISSUE;
          cmd_n     = req_cmd[int'(arb_idx)*CMD_W +: CMD_W];
          gid_n     = arb_idx;
          ack_n     = arb_grant;
          ptr_n     = (arb_idx == GID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          str_n     = 1'b1;
          str_cnt_n = STR_W'(1);
        end
      end
      ISSUE: begin
        // str_cnt counts strobe cycles already driven, including the grant cycle
        if (str_cnt >= STR_W'(STR_CYCLES)) begin
          state_n  = WAIT_BUSY;
          to_cnt_n = '0;
        end else begin
          str_n     = 1'b1;
          str_cnt_n = str_cnt + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!ready_in) begin
          state_n = WAIT_DONE;
        end else if (to_cnt >= TO_W'(ACK_TIMEOUT - 1)) begin
          to_err_n  = 1'b1;
          state_n   = GAP;
          gap_cnt_n = '0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (ready_in) begin
          done_n[grant_id] = 1'b1;
          state_n          = GAP;
          gap_cnt_n        = '0;
        end
      end
      GAP: begin
        if (gap_cnt >= GAP_W'(GAP_LAST_I)) state_n = IDLE;
        else gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      str_cnt     <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      rr_ptr      <= '0;
      cmd_out     <= '0;
      grant_id    <= '0;
      req_ack     <= '0;
      req_done    <= '0;
      str_out     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      str_cnt     <= str_cnt_n;
      to_cnt      <= to_cnt_n;
      gap_cnt     <= gap_cnt_n;
      rr_ptr      <= ptr_n;
      cmd_out     <= cmd_n;
      grant_id    <= gid_n;
      req_ack     <= ack_n;
      req_done    <= done_n;
      str_out     <= str_n;
      timeout_err <= to_err_n;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_comunicaciones_cmd_sched.sv
// Directed bench for comunicaciones_cmd_sched with a simple core model on ready_in.
module tb_comunicaciones_cmd_sched;
  import comunicaciones_pkg::*;

  localparam int N_REQ = 4;
  localparam int CMD_W = 8;
  localparam int STR_CYCLES = 5;
  localparam int ACK_TIMEOUT = 1023;
  localparam int GAP_CYCLES = 16;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic [N_REQ-1:0]       req_ack;
  logic [N_REQ-1:0]       req_done;
  logic [CMD_W-1:0]       cmd_out;
  logic                   str_out;
  logic                   ready_in;
  logic                   busy;
  logic [1:0]             grant_id;
  logic                   timeout_err;
  state_t                 dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  comunicaciones_cmd_sched #(
    .N_REQ(N_REQ), .CMD_W(CMD_W), .STR_CYCLES(STR_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ack(req_ack), .req_done(req_done), .cmd_out(cmd_out), .str_out(str_out),
    .ready_in(ready_in), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Core model: goes busy on the first strobe cycle for busy_len cycles
  bit core_stuck = 1'b0;
  bit core_hold_low = 1'b0;
  int busy_len = 100;
  int core_cnt = 0;

  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (core_hold_low) ready_in = 1'b0;
      else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) ready_in = 1'b1;
      end else if (str_out && !core_stuck) begin
        ready_in = 1'b0;
        core_cnt = busy_len;
      end else ready_in = 1'b1;
    end
  end

  // Monitor: event counters and invariants
  int done_cnt[N_REQ];
  int ack_total = 0;
  int to_total = 0;
  int onehot_bad = 0;
  int cmd_bad = 0;
  logic prev_str = 1'b0;
  logic [CMD_W-1:0] prev_cmd = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!$onehot0(req_ack) || !$onehot0(req_done)) onehot_bad++;
      if (prev_str && str_out && cmd_out !== prev_cmd) cmd_bad++;
      for (int i = 0; i < N_REQ; i++) if (req_done[i]) done_cnt[i]++;
      if (|req_ack) ack_total++;
      if (timeout_err) to_total++;
    end
    prev_str = str_out;
    prev_cmd = cmd_out;
  end

  // Driver tasks
  task automatic wait_ack(input int budget, output logic [N_REQ-1:0] got, output int waited);
    bit hit = 1'b0;
    got = '0;
    waited = budget;
    for (int c = 0; c < budget && !hit; c++) begin
      @(negedge clk);
      if (|req_ack) begin got = req_ack; waited = c; hit = 1'b1; end
    end
  endtask

  task automatic wait_done(input int budget, output logic [N_REQ-1:0] got);
    bit hit = 1'b0;
    got = '0;
    for (int c = 0; c < budget && !hit; c++) begin
      @(negedge clk);
      if (|req_done) begin got = req_done; hit = 1'b1; end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && busy; c++) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_wait: busy=%b required 0", busy); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL rst_ack: got %b required 0000", req_ack); end
    n_tests++; if (req_done !== 4'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0000", req_done); end
    n_tests++; if (cmd_out !== 8'h00) begin n_fail++; $display("FAIL rst_cmd: got %h required 00", cmd_out); end
    n_tests++; if (str_out !== 1'b0) begin n_fail++; $display("FAIL rst_str: got %b required 0", str_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d required 0", grant_id); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_to: got %b required 0", timeout_err); end
    n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required IDLE", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] got;
    int w, s, g, rise_at, done_at;
    logic prev_r;
    @(negedge clk);
    req_cmd = '0;
    req_cmd[7:0] = 8'h01;
    req_valid = 4'b0001;
    wait_ack(50, got, w);
    req_valid = '0;
    n_tests++; if (got !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b required 0001", got); end
    n_tests++; if (w != 0) begin n_fail++; $display("FAIL single_latency: got %0d extra cycles required 0", w); end
    n_tests++; if (cmd_out !== 8'h01) begin n_fail++; $display("FAIL single_cmd: got %h required 01", cmd_out); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_gid: got %0d required 0", grant_id); end
    s = 0;
    while (str_out === 1'b1 && s < 20) begin s++; @(negedge clk); end
    n_tests++; if (s != STR_CYCLES) begin n_fail++; $display("FAIL single_str_len: got %0d required %0d", s, STR_CYCLES); end
    rise_at = -1; done_at = -1; got = '0; prev_r = ready_in;
    for (int c = 0; c < 300 && done_at < 0; c++) begin
      @(negedge clk);
      if (ready_in && !prev_r && rise_at < 0) rise_at = c;
      prev_r = ready_in;
      if (|req_done) begin done_at = c; got = req_done; end
    end
    n_tests++; if (got !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b required 0001", got); end
    n_tests++; if (done_at != rise_at + 1 || rise_at < 0) begin n_fail++; $display("FAIL single_done_lat: done at %0d required %0d", done_at, rise_at + 1); end
    g = 0;
    while (busy === 1'b1 && g < 40) begin g++; @(negedge clk); end
    n_tests++; if (g != GAP_CYCLES) begin n_fail++; $display("FAIL single_gap: got %0d required %0d", g, GAP_CYCLES); end
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] got, exp_g;
    logic [CMD_W-1:0] exp_cmd [N_REQ];
    int w, done_cyc, base [N_REQ];
    exp_cmd = '{8'h00, 8'h01, 8'h02, 8'h04};
    do_reset();
    for (int i = 0; i < N_REQ; i++) base[i] = done_cnt[i];
    req_cmd = {8'h04, 8'h02, 8'h01, 8'h00};
    req_valid = 4'b1111;
    done_cyc = 0;
    for (int k = 0; k < N_REQ; k++) begin
      exp_g = 4'(1 << k);
      wait_ack(300, got, w);
      req_valid[k] = 1'b0;
      n_tests++; if (got !== exp_g) begin n_fail++; $display("FAIL b2b_ack%0d: got %b required %b", k, got, exp_g); end
      n_tests++; if (cmd_out !== exp_cmd[k]) begin n_fail++; $display("FAIL b2b_cmd%0d: got %h required %h", k, cmd_out, exp_cmd[k]); end
      if (k > 0) begin
        n_tests++; if (cyc - done_cyc < GAP_CYCLES) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d cycles required >= %0d", k, cyc - done_cyc, GAP_CYCLES); end
      end
      wait_done(300, got);
      done_cyc = cyc;
      n_tests++; if (got !== exp_g) begin n_fail++; $display("FAIL b2b_done%0d: got %b required %b", k, got, exp_g); end
    end
    wait_idle(60);
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      n_tests++; if (done_cnt[i] - base[i] != 1) begin n_fail++; $display("FAIL b2b_done_count%0d: got %0d required 1", i, done_cnt[i] - base[i]); end
    end
  endtask

  task automatic test_fairness();
    logic [N_REQ-1:0] got;
    int w;
    do_reset();
    req_cmd = {8'h33, 8'h22, 8'h11, 8'h10};
    req_valid = 4'b0001;
    wait_ack(50, got, w);
    n_tests++; if (got !== 4'b0001) begin n_fail++; $display("FAIL fair_first: got %b required 0001", got); end
    repeat (20) @(negedge clk);
    req_valid[2] = 1'b1;
    wait_ack(400, got, w);
    req_valid[2] = 1'b0;
    n_tests++; if (got !== 4'b0100) begin n_fail++; $display("FAIL fair_second: got %b required 0100", got); end
    n_tests++; if (cmd_out !== 8'h22) begin n_fail++; $display("FAIL fair_cmd: got %h required 22", cmd_out); end
    wait_ack(400, got, w);
    req_valid = '0;
    n_tests++; if (got !== 4'b0001) begin n_fail++; $display("FAIL fair_third: got %b required 0001", got); end
    n_tests++; if (cmd_out !== 8'h10) begin n_fail++; $display("FAIL fair_cmd3: got %h required 10", cmd_out); end
    wait_idle(300);
  endtask

  task automatic test_timeout();
    logic [N_REQ-1:0] got;
    int w, t, g, s, to_base, base [N_REQ];
    for (int i = 0; i < N_REQ; i++) base[i] = done_cnt[i];
    to_base = to_total;
    @(negedge clk);
    core_stuck = 1'b1;
    req_cmd[15:8] = 8'h5A;
    req_valid = 4'b0010;
    wait_ack(50, got, w);
    req_valid = '0;
    n_tests++; if (got !== 4'b0010) begin n_fail++; $display("FAIL to_ack: got %b required 0010", got); end
    s = 0;
    while (str_out === 1'b1 && s < 20) begin s++; @(negedge clk); end
    t = -1;
    for (int c = 0; c < 1100 && t < 0; c++) begin
      if (timeout_err === 1'b1) t = c;
      else @(negedge clk);
    end
    n_tests++; if (t != ACK_TIMEOUT) begin n_fail++; $display("FAIL to_delay: got %0d required %0d", t, ACK_TIMEOUT); end
    @(negedge clk);
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b required 0", timeout_err); end
    g = 1;
    while (busy === 1'b1 && g < 40) begin g++; @(negedge clk); end
    n_tests++; if (g != GAP_CYCLES) begin n_fail++; $display("FAIL to_gap: got %0d required %0d", g, GAP_CYCLES); end
    @(negedge clk);
    n_tests++; if (to_total - to_base != 1) begin n_fail++; $display("FAIL to_count: got %0d required 1", to_total - to_base); end
    n_tests++; if (done_cnt[1] != base[1]) begin n_fail++; $display("FAIL to_no_done: got %0d required %0d", done_cnt[1], base[1]); end
    core_stuck = 1'b0;
  endtask

  task automatic test_not_ready();
    logic [N_REQ-1:0] got;
    int w, ack_base;
    @(negedge clk);
    core_hold_low = 1'b1;
    repeat (3) @(negedge clk);
    ack_base = ack_total;
    req_cmd[31:24] = 8'hC3;
    req_valid = 4'b1000;
    repeat (10) @(negedge clk);
    n_tests++; if (ack_total != ack_base) begin n_fail++; $display("FAIL nr_no_ack: got %0d acks required 0", ack_total - ack_base); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nr_busy: got %b required 0", busy); end
    core_hold_low = 1'b0;
    wait_ack(20, got, w);
    req_valid = '0;
    n_tests++; if (got !== 4'b1000) begin n_fail++; $display("FAIL nr_ack: got %b required 1000", got); end
    n_tests++; if (w != 1) begin n_fail++; $display("FAIL nr_latency: got %0d required 1", w); end
    n_tests++; if (cmd_out !== 8'hC3 || str_out !== 1'b1) begin n_fail++; $display("FAIL nr_issue: cmd %h str %b required C3 1", cmd_out, str_out); end
    wait_done(300, got);
    n_tests++; if (got !== 4'b1000) begin n_fail++; $display("FAIL nr_done: got %b required 1000", got); end
    wait_idle(60);
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] got;
    int w, base [N_REQ];
    @(negedge clk);
    req_cmd[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_ack(50, got, w);
    req_valid = '0;
    n_tests++; if (got !== 4'b0001) begin n_fail++; $display("FAIL rm_ack: got %b required 0001", got); end
    repeat (20) @(negedge clk);
    n_tests++; if (dbg_state !== WAIT_DONE) begin n_fail++; $display("FAIL rm_state: got %0d required WAIT_DONE", dbg_state); end
    for (int i = 0; i < N_REQ; i++) base[i] = done_cnt[i];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (str_out !== 1'b0 || busy !== 1'b0 || cmd_out !== 8'h00) begin n_fail++; $display("FAIL rm_outputs: str %b busy %b cmd %h required 0 0 00", str_out, busy, cmd_out); end
    n_tests++; if (grant_id !== 2'd0 || req_ack !== 4'b0) begin n_fail++; $display("FAIL rm_gid_ack: gid %0d ack %b required 0 0000", grant_id, req_ack); end
    repeat (150) @(negedge clk);
    n_tests++; if (done_cnt[0] != base[0]) begin n_fail++; $display("FAIL rm_no_done: got %0d required %0d", done_cnt[0], base[0]); end
    req_cmd[23:16] = 8'h7E;
    req_valid = 4'b0100;
    wait_ack(20, got, w);
    req_valid = '0;
    n_tests++; if (got !== 4'b0100 || w != 0) begin n_fail++; $display("FAIL rm_new_ack: got %b after %0d required 0100 after 0", got, w); end
    n_tests++; if (cmd_out !== 8'h7E) begin n_fail++; $display("FAIL rm_new_cmd: got %h required 7E", cmd_out); end
    wait_done(300, got);
    n_tests++; if (got !== 4'b0100) begin n_fail++; $display("FAIL rm_new_done: got %b required 0100", got); end
    wait_idle(60);
  endtask

  task automatic test_invariants();
    n_tests++; if (onehot_bad != 0) begin n_fail++; $display("FAIL onehot: got %0d violations required 0", onehot_bad); end
    n_tests++; if (cmd_bad != 0) begin n_fail++; $display("FAIL cmd_stable: got %0d changes under str required 0", cmd_bad); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    for (int i = 0; i < N_REQ; i++) done_cnt[i] = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_timeout();
    test_not_ready();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
